// File: rtl/vc_input_port.sv
// vc_input_port: router input port with VC_NUM per-VC flit FIFOs, a per-VC
// packet FSM (IDLE -> VA -> ACTIVE) with XY routing on head flits, VC
// allocation requests, switch-side readout and per-VC on/off backpressure.
// Optional build macro CREDIT_RETURN_EN: adds credit_o (one-cycle pulse per
// popped flit, registered) and ties on_off_o high.

package vc_input_port_pkg;
    localparam int MESH_SIZE_X = 4;
    localparam int MESH_SIZE_Y = 4;
    localparam int VC_NUM_DEF  = 2;
    localparam int VC_ID_W     = (VC_NUM_DEF > 1) ? $clog2(VC_NUM_DEF) : 1;
    localparam int DEST_W      = 4;

    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_label_t;

    typedef enum logic [2:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        SOUTH = 3'd2,
        WEST  = 3'd3,
        EAST  = 3'd4
    } port_t;

    typedef struct packed {
        flit_label_t         flit_label;
        logic [VC_ID_W-1:0]  vc_id;
        logic [DEST_W-1:0]   x_dest;
        logic [DEST_W-1:0]   y_dest;
        logic [15:0]         payload;
    } flit_t;
endpackage

module vc_input_port
    import vc_input_port_pkg::*;
#(
    parameter int VC_NUM         = VC_NUM_DEF,
    parameter int BUFFER_SIZE    = 8,
    parameter int PIPELINE_DEPTH = 5,
    parameter int X_CURRENT      = MESH_SIZE_X / 2,
    parameter int Y_CURRENT      = MESH_SIZE_Y / 2,
    localparam int VC_SIZE       = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  flit_t               data_i,
    input  logic                valid_flit_i,
    input  logic [VC_SIZE-1:0]  vc_sel_i,
    input  logic                valid_sel_i,
    input  logic [VC_SIZE-1:0]  vc_new_i [VC_NUM],
    input  logic [VC_NUM-1:0]   vc_valid_i,
    output flit_t               flit_o,
    output logic                valid_flit_o,
    output logic [VC_NUM-1:0]   on_off_o,
    output logic [VC_NUM-1:0]   vc_allocatable_o,
    output logic [VC_NUM-1:0]   vc_request_o,
    output port_t               out_port_o [VC_NUM],
    output logic [VC_NUM-1:0]   error_o
`ifdef CREDIT_RETURN_EN
    ,
    output logic [VC_NUM-1:0]   credit_o
`endif
);

    localparam int PTR_W = $clog2(BUFFER_SIZE);
    localparam int CNT_W = PTR_W + 1;
    localparam int ON_TH = BUFFER_SIZE - PIPELINE_DEPTH + 1;

    typedef enum logic [1:0] {S_IDLE, S_VA, S_ACTIVE} vc_state_t;

    // Dimension-ordered routing: resolve X first, then Y
    function automatic port_t route(input flit_t f);
        port_t p;
        if (int'(f.x_dest) > X_CURRENT)      p = EAST;
        else if (int'(f.x_dest) < X_CURRENT) p = WEST;
        else if (int'(f.y_dest) > Y_CURRENT) p = SOUTH;
        else if (int'(f.y_dest) < Y_CURRENT) p = NORTH;
        else                                 p = LOCAL;
        return p;
    endfunction

    flit_t              head_w [VC_NUM];
    logic [VC_SIZE-1:0] dvc_w  [VC_NUM];
    logic [VC_NUM-1:0]  pop_w;

    genvar gi;
    generate
        for (gi = 0; gi < VC_NUM; gi++) begin : g_vc
            flit_t              mem_q [BUFFER_SIZE];
            logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
            logic [CNT_W-1:0]   count_q, count_d;
            vc_state_t          state_q, state_d;
            port_t              out_port_q, out_port_d;
            logic [VC_SIZE-1:0] dvc_q, dvc_d;
            logic               error_q, error_d;
            logic               push_req, push_ok, nonempty, full;
            logic               pop, discard, rd;
            flit_t              head;

            assign head     = mem_q[rd_ptr_q];
            assign nonempty = (count_q != '0);
            assign full     = (count_q == CNT_W'(BUFFER_SIZE));
            assign push_req = valid_flit_i && (data_i.vc_id == VC_ID_W'(gi));
            assign pop      = valid_sel_i && (vc_sel_i == VC_SIZE'(gi))
                              && (state_q == S_ACTIVE) && nonempty;

            // Packet FSM plus FIFO pointer/occupancy bookkeeping
            always_comb begin
                state_d    = state_q;
                out_port_d = out_port_q;
                dvc_d      = dvc_q;
                error_d    = error_q;
                discard    = 1'b0;
                case (state_q)
                    S_IDLE: begin
                        if (nonempty) begin
                            if (head.flit_label == HEAD || head.flit_label == HEADTAIL) begin
                                out_port_d = route(head);
                                state_d    = S_VA;
                            end else begin
                                // stray body/tail with no open packet
                                discard = 1'b1;
                                error_d = 1'b1;
                            end
                        end
                    end
                    S_VA: begin
                        if (vc_valid_i[gi]) begin
                            dvc_d   = vc_new_i[gi];
                            state_d = S_ACTIVE;
                        end
                    end
                    S_ACTIVE: begin
                        if (pop && (head.flit_label == TAIL || head.flit_label == HEADTAIL))
                            state_d = S_IDLE;
                    end
                    default: state_d = S_IDLE;
                endcase
                rd      = pop | discard;
                // a full FIFO still takes a write when the same VC drains this cycle
                push_ok = push_req && (!full || pop);
                if (push_req && !push_ok)
                    error_d = 1'b1;
                rd_ptr_d = rd_ptr_q + PTR_W'(rd);
                wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
                count_d  = count_q + CNT_W'(push_ok) - CNT_W'(rd);
            end

            // Flit storage; occupancy gates every use, so no reset is needed
            always_ff @(posedge clk) begin
                if (push_ok)
                    mem_q[wr_ptr_q] <= data_i;
            end

            // Per-VC state registers with asynchronous clear
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    rd_ptr_q   <= '0;
                    wr_ptr_q   <= '0;
                    count_q    <= '0;
                    state_q    <= S_IDLE;
                    out_port_q <= LOCAL;
                    dvc_q      <= '0;
                    error_q    <= 1'b0;
                end else begin
                    rd_ptr_q   <= rd_ptr_d;
                    wr_ptr_q   <= wr_ptr_d;
                    count_q    <= count_d;
                    state_q    <= state_d;
                    out_port_q <= out_port_d;
                    dvc_q      <= dvc_d;
                    error_q    <= error_d;
                end
            end

            assign head_w[gi]           = head;
            assign dvc_w[gi]            = dvc_q;
            assign pop_w[gi]            = pop;
            assign vc_allocatable_o[gi] = (state_q == S_IDLE) && !nonempty;
            assign vc_request_o[gi]     = (state_q == S_VA);
            assign out_port_o[gi]       = out_port_q;
            assign error_o[gi]          = error_q;
`ifdef CREDIT_RETURN_EN
            assign on_off_o[gi]         = 1'b1;
`else
            assign on_off_o[gi]         = (count_q < CNT_W'(ON_TH));
`endif
        end
    endgenerate

    // Switch-side readout: head of the selected VC relabelled with its downstream VC
    always_comb begin
        flit_o       = '0;
        valid_flit_o = 1'b0;
        for (int v = 0; v < VC_NUM; v++) begin
            if (pop_w[v]) begin
                flit_o       = head_w[v];
                flit_o.vc_id = VC_ID_W'(dvc_w[v]);
                valid_flit_o = 1'b1;
            end
        end
    end

`ifdef CREDIT_RETURN_EN
    logic [VC_NUM-1:0] credit_q, credit_d;

    // One credit per flit that left the port last cycle
    always_comb begin
        credit_d = pop_w;
    end

    // Credit pulse register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) credit_q <= '0;
        else      credit_q <= credit_d;
    end

    assign credit_o = credit_q;
`endif

endmodule
